// File: rtl/el_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : el_pkg
//  Description : Shared types and constants for the bit-serial dual-rail
//                full-adder sequencer (state encoding, rail indices,
//                seen-flag and synchronizer-bus bit positions).
//  Revision    : 1.0 - initial release
// ============================================================================
package el_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        WAIT  = 3'd2,
        ACK   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Rail indices of a dual-rail pair; rail[1] carries logic 1
    localparam int RAIL0    = 0;
    localparam int RAIL1    = 1;
    localparam int RAIL_NUM = 2;

    // Per-bit seen flags: three input acks plus the two FA outputs
    localparam int SEEN_A   = 0;
    localparam int SEEN_B   = 1;
    localparam int SEEN_C   = 2;
    localparam int SEEN_S   = 3;
    localparam int SEEN_CO  = 4;
    localparam int SEEN_NUM = 5;

    // Layout of the FA-to-controller bus that crosses the synchronizer
    localparam int SB_ACK_A = 0;
    localparam int SB_ACK_B = 1;
    localparam int SB_ACK_C = 2;
    localparam int SB_OUT_S = 3;   // two bits: [4:3]
    localparam int SB_OUT_C = 5;   // two bits: [6:5]
    localparam int SB_WIDTH = 7;

    // One-hot toggle mask that sends a token of value v on a rail pair
    function automatic logic [RAIL_NUM-1:0] rail_token(input logic v);
        logic [RAIL_NUM-1:0] t;
        t = '0;
        if (v) t[RAIL1] = 1'b1;
        else   t[RAIL0] = 1'b1;
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/el_sync.sv
`default_nettype none
// ============================================================================
//  Module      : el_sync
//  Description : STAGES-deep, WIDTH-bit flip-flop synchronizer chain with
//                asynchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module el_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    // Fewer than two stages gives no metastability protection
    localparam int STAGES_EFF = (STAGES < 2) ? 2 : STAGES;
    localparam int CHAIN_W    = STAGES_EFF * WIDTH;

    logic [CHAIN_W-1:0] r_chain_q;
    logic [CHAIN_W-1:0] w_chain_d;

    // Shift the new sample in at the bottom of the chain
    always_comb begin
        w_chain_d = {r_chain_q[CHAIN_W-WIDTH-1:0], i_data};
    end

    // Chain register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_chain_q <= '0;
        else        r_chain_q <= w_chain_d;
    end

    assign o_data = r_chain_q[CHAIN_W-1 -: WIDTH];

endmodule
`default_nettype wire

// File: rtl/el_fa_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : el_fa_serial_ctrl
//  Description : Clocked sequencer that runs a 2-phase dual-rail full adder
//                as a bit-serial WIDTH-bit adder, LSB first, feeding the FA
//                carry-out back as the next carry-in.
//                Optional WAIT watchdog: define EL_FA_CTRL_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module el_fa_serial_ctrl
    import el_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             busy,
    output logic             err,
    output logic             timeout,
    output logic [1:0]       fa_in_a,
    output logic [1:0]       fa_in_b,
    output logic [1:0]       fa_in_c,
    input  logic             fa_ack_a,
    input  logic             fa_ack_b,
    input  logic             fa_ack_c,
    input  logic [1:0]       fa_out_s,
    input  logic [1:0]       fa_out_c,
    output logic             fa_ack_s,
    output logic             fa_ack_c_o
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t                r_state_q,   w_state_d;
    logic [WIDTH-1:0]      r_a_q,       w_a_d;
    logic [WIDTH-1:0]      r_b_q,       w_b_d;
    logic [WIDTH-1:0]      r_sum_q,     w_sum_d;
    logic                  r_carry_q,   w_carry_d;
    logic [IDX_W-1:0]      r_idx_q,     w_idx_d;
    logic [SEEN_NUM-1:0]   r_seen_q,    w_seen_d;
    logic [2:0]            r_ack_mir_q, w_ack_mir_d;
    logic [RAIL_NUM-1:0]   r_s_mir_q,   w_s_mir_d;
    logic [RAIL_NUM-1:0]   r_c_mir_q,   w_c_mir_d;
    logic [RAIL_NUM-1:0]   r_in_a_q,    w_in_a_d;
    logic [RAIL_NUM-1:0]   r_in_b_q,    w_in_b_d;
    logic [RAIL_NUM-1:0]   r_in_c_q,    w_in_c_d;
    logic                  r_ack_s_q,   w_ack_s_d;
    logic                  r_ack_c_q,   w_ack_c_d;
    logic                  r_err_q,     w_err_d;

`ifdef EL_FA_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      r_wcnt_q,    w_wcnt_d;
    logic                  r_timeout_q, w_timeout_d;
`endif

    logic [SB_WIDTH-1:0]   w_fa_raw;
    logic [SB_WIDTH-1:0]   w_fa_sync;
    logic [2:0]            w_ack_chg;
    logic [RAIL_NUM-1:0]   w_s_chg;
    logic [RAIL_NUM-1:0]   w_c_chg;

    assign w_fa_raw = {fa_out_c, fa_out_s, fa_ack_c, fa_ack_b, fa_ack_a};

    el_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (SB_WIDTH)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (w_fa_raw),
        .o_data (w_fa_sync)
    );

    // A transition on any synced signal relative to its mirror is an event
    assign w_ack_chg = w_fa_sync[SB_ACK_C:SB_ACK_A] ^ r_ack_mir_q;
    assign w_s_chg   = w_fa_sync[SB_OUT_S +: RAIL_NUM] ^ r_s_mir_q;
    assign w_c_chg   = w_fa_sync[SB_OUT_C +: RAIL_NUM] ^ r_c_mir_q;

    // Next-state, datapath and handshake-event bookkeeping
    always_comb begin
        w_state_d   = r_state_q;
        w_a_d       = r_a_q;
        w_b_d       = r_b_q;
        w_sum_d     = r_sum_q;
        w_carry_d   = r_carry_q;
        w_idx_d     = r_idx_q;
        w_seen_d    = r_seen_q;
        w_ack_mir_d = r_ack_mir_q;
        w_s_mir_d   = r_s_mir_q;
        w_c_mir_d   = r_c_mir_q;
        w_in_a_d    = r_in_a_q;
        w_in_b_d    = r_in_b_q;
        w_in_c_d    = r_in_c_q;
        w_ack_s_d   = r_ack_s_q;
        w_ack_c_d   = r_ack_c_q;
        w_err_d     = r_err_q;
`ifdef EL_FA_CTRL_TIMEOUT_EN
        w_wcnt_d    = r_wcnt_q;
        w_timeout_d = r_timeout_q;
`endif

        unique case (r_state_q)
            IDLE: begin
                if (op_valid) begin
                    w_a_d     = op_a;
                    w_b_d     = op_b;
                    w_carry_d = op_cin;
                    w_sum_d   = '0;
                    w_idx_d   = '0;
                    w_state_d = DRIVE;
                end
            end
            DRIVE: begin
                // All three input tokens of this bit leave together
                w_in_a_d  = r_in_a_q ^ rail_token(r_a_q[r_idx_q]);
                w_in_b_d  = r_in_b_q ^ rail_token(r_b_q[r_idx_q]);
                w_in_c_d  = r_in_c_q ^ rail_token(r_carry_q);
                w_seen_d  = '0;
`ifdef EL_FA_CTRL_TIMEOUT_EN
                w_wcnt_d  = '0;
`endif
                w_state_d = WAIT;
            end
            WAIT: begin
                w_ack_mir_d = w_fa_sync[SB_ACK_C:SB_ACK_A];
                w_s_mir_d   = w_fa_sync[SB_OUT_S +: RAIL_NUM];
                w_c_mir_d   = w_fa_sync[SB_OUT_C +: RAIL_NUM];
                w_seen_d[SEEN_A]  = r_seen_q[SEEN_A]  | w_ack_chg[0];
                w_seen_d[SEEN_B]  = r_seen_q[SEEN_B]  | w_ack_chg[1];
                w_seen_d[SEEN_C]  = r_seen_q[SEEN_C]  | w_ack_chg[2];
                w_seen_d[SEEN_S]  = r_seen_q[SEEN_S]  | (|w_s_chg);
                w_seen_d[SEEN_CO] = r_seen_q[SEEN_CO] | (|w_c_chg);
                // Both rails toggling is illegal; keep rail[1] as the value
                if (|w_s_chg) w_sum_d[r_idx_q] = w_s_chg[RAIL1];
                if (|w_c_chg) w_carry_d        = w_c_chg[RAIL1];
                if ((&w_s_chg) || (&w_c_chg)) w_err_d = 1'b1;
                if (&w_seen_d) begin
                    w_state_d = ACK;
                end
`ifdef EL_FA_CTRL_TIMEOUT_EN
                else begin
                    w_wcnt_d = r_wcnt_q + CNT_W'(1);
                    if (w_wcnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        w_timeout_d = 1'b1;
                        w_state_d   = IDLE;
                    end
                end
`endif
            end
            ACK: begin
                w_ack_s_d = ~r_ack_s_q;
                w_ack_c_d = ~r_ack_c_q;
                if (r_idx_q == IDX_W'(WIDTH - 1)) begin
                    w_state_d = DONE;
                end else begin
                    w_idx_d   = r_idx_q + IDX_W'(1);
                    w_state_d = DRIVE;
                end
            end
            DONE: begin
                if (res_ready) w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q   <= IDLE;
            r_a_q       <= '0;
            r_b_q       <= '0;
            r_sum_q     <= '0;
            r_carry_q   <= 1'b0;
            r_idx_q     <= '0;
            r_seen_q    <= '0;
            r_ack_mir_q <= '0;
            r_s_mir_q   <= '0;
            r_c_mir_q   <= '0;
            r_in_a_q    <= '0;
            r_in_b_q    <= '0;
            r_in_c_q    <= '0;
            r_ack_s_q   <= 1'b0;
            r_ack_c_q   <= 1'b0;
            r_err_q     <= 1'b0;
`ifdef EL_FA_CTRL_TIMEOUT_EN
            r_wcnt_q    <= '0;
            r_timeout_q <= 1'b0;
`endif
        end else begin
            r_state_q   <= w_state_d;
            r_a_q       <= w_a_d;
            r_b_q       <= w_b_d;
            r_sum_q     <= w_sum_d;
            r_carry_q   <= w_carry_d;
            r_idx_q     <= w_idx_d;
            r_seen_q    <= w_seen_d;
            r_ack_mir_q <= w_ack_mir_d;
            r_s_mir_q   <= w_s_mir_d;
            r_c_mir_q   <= w_c_mir_d;
            r_in_a_q    <= w_in_a_d;
            r_in_b_q    <= w_in_b_d;
            r_in_c_q    <= w_in_c_d;
            r_ack_s_q   <= w_ack_s_d;
            r_ack_c_q   <= w_ack_c_d;
            r_err_q     <= w_err_d;
`ifdef EL_FA_CTRL_TIMEOUT_EN
            r_wcnt_q    <= w_wcnt_d;
            r_timeout_q <= w_timeout_d;
`endif
        end
    end

    assign op_ready   = (r_state_q == IDLE);
    assign busy       = (r_state_q != IDLE);
    assign res_valid  = (r_state_q == DONE);
    assign res_sum    = (r_state_q == DONE) ? r_sum_q : '0;
    assign res_cout   = (r_state_q == DONE) ? r_carry_q : 1'b0;
    assign err        = r_err_q;
    assign fa_in_a    = r_in_a_q;
    assign fa_in_b    = r_in_b_q;
    assign fa_in_c    = r_in_c_q;
    assign fa_ack_s   = r_ack_s_q;
    assign fa_ack_c_o = r_ack_c_q;
`ifdef EL_FA_CTRL_TIMEOUT_EN
    assign timeout    = r_timeout_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_el_fa_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_el_fa_serial_ctrl
//  Description : Self-checking bench for el_fa_serial_ctrl with a behavioural
//                2-phase dual-rail full-adder model and a result scoreboard.
//                Covers the watchdog when EL_FA_CTRL_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_el_fa_serial_ctrl;

    localparam int OP_BUDGET  = 2000;
    localparam int RES_BUDGET = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic       op_cin = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_sum;
    logic       res_cout;
    logic       busy, err, timeout;
    logic [1:0] fa_in_a, fa_in_b, fa_in_c;
    logic       fa_ack_a, fa_ack_b, fa_ack_c;
    logic [1:0] fa_out_s, fa_out_c;
    logic       fa_ack_s, fa_ack_c_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] sb_q[$];

    // Model controls, written by the stimulus process only
    int   model_mode = 0;   // 0 random, 1 carry first, 2 all together, 3 silent
    logic inj_bit3   = 1'b0;

    el_fa_serial_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout),
        .busy(busy), .err(err), .timeout(timeout),
        .fa_in_a(fa_in_a), .fa_in_b(fa_in_b), .fa_in_c(fa_in_c),
        .fa_ack_a(fa_ack_a), .fa_ack_b(fa_ack_b), .fa_ack_c(fa_ack_c),
        .fa_out_s(fa_out_s), .fa_out_c(fa_out_c),
        .fa_ack_s(fa_ack_s), .fa_ack_c_o(fa_ack_c_o)
    );

    always #5 clk = ~clk;

    // Behavioural 2-phase full adder: waits for three input tokens, then
    // emits acks and outputs after per-signal delays, then waits for acks
    int         ms = 0, tcount = 0, bitcnt = 0;
    int         d0 = 0, d1 = 0, d2 = 0, d3 = 0, d4 = 0, dmax = 0;
    logic [1:0] m_a = '0, m_b = '0, m_c = '0;
    logic       m_as = 1'b0, m_ac = 1'b0;
    logic       mdl_s = 1'b0, mdl_co = 1'b0, mdl_inj = 1'b0;

    always @(negedge clk or negedge rst_n) begin : fa_model
        logic va, vb, vc;
        int t0, t1, t2, t3, t4, tm;
        if (!rst_n) begin
            fa_ack_a <= 1'b0; fa_ack_b <= 1'b0; fa_ack_c <= 1'b0;
            fa_out_s <= '0;   fa_out_c <= '0;
            m_a <= '0; m_b <= '0; m_c <= '0; m_as <= 1'b0; m_ac <= 1'b0;
            ms <= 0; tcount <= 0; bitcnt <= 0;
        end else begin
            case (ms)
                0: if ((fa_in_a != m_a) && (fa_in_b != m_b) && (fa_in_c != m_c)) begin
                    va = fa_in_a[1] ^ m_a[1];
                    vb = fa_in_b[1] ^ m_b[1];
                    vc = fa_in_c[1] ^ m_c[1];
                    m_a <= fa_in_a; m_b <= fa_in_b; m_c <= fa_in_c;
                    mdl_s   <= va ^ vb ^ vc;
                    mdl_co  <= (va & vb) | (va & vc) | (vb & vc);
                    mdl_inj <= inj_bit3 && (bitcnt == 3);
                    bitcnt  <= (bitcnt == 7) ? 0 : bitcnt + 1;
                    case (model_mode)
                        1: begin
                            t4 = 1; t3 = $urandom_range(20, 1);
                            t0 = $urandom_range(20, 4); t1 = $urandom_range(20, 4);
                            t2 = $urandom_range(20, 4);
                        end
                        2: begin
                            t0 = $urandom_range(20, 1);
                            t1 = t0; t2 = t0; t3 = t0; t4 = t0;
                        end
                        3: begin
                            t0 = 0; t1 = 0; t2 = 0; t3 = 0; t4 = 0;
                        end
                        default: begin
                            t0 = $urandom_range(20, 1); t1 = $urandom_range(20, 1);
                            t2 = $urandom_range(20, 1); t3 = $urandom_range(20, 1);
                            t4 = $urandom_range(20, 1);
                        end
                    endcase
                    tm = t0;
                    if (t1 > tm) tm = t1;
                    if (t2 > tm) tm = t2;
                    if (t3 > tm) tm = t3;
                    if (t4 > tm) tm = t4;
                    d0 <= t0; d1 <= t1; d2 <= t2; d3 <= t3; d4 <= t4; dmax <= tm;
                    tcount <= 0;
                    ms <= 1;
                end
                1: begin
                    tcount <= tcount + 1;
                    if (d0 == tcount + 1) fa_ack_a <= ~fa_ack_a;
                    if (d1 == tcount + 1) fa_ack_b <= ~fa_ack_b;
                    if (d2 == tcount + 1) fa_ack_c <= ~fa_ack_c;
                    if (d3 == tcount + 1)
                        fa_out_s <= fa_out_s ^ (mdl_inj ? 2'b11 : (mdl_s ? 2'b10 : 2'b01));
                    if (d4 == tcount + 1)
                        fa_out_c <= fa_out_c ^ (mdl_co ? 2'b10 : 2'b01);
                    if (dmax == tcount + 1) ms <= 2;
                end
                default: if ((fa_ack_s != m_as) && (fa_ack_c_o != m_ac)) begin
                    m_as <= fa_ack_s; m_ac <= fa_ack_c_o;
                    ms <= 0;
                end
            endcase
        end
    end

    // Rail toggle counters (free-running; stimulus uses differences)
    int cnt_a0 = 0, cnt_a1 = 0, cnt_b0 = 0, cnt_c0 = 0, cnt_acks = 0;
    logic [1:0] p_a = '0, p_b = '0, p_c = '0;
    logic       p_s = 1'b0;
    always @(posedge clk) begin
        if (fa_in_a[0] != p_a[0]) cnt_a0++;
        if (fa_in_a[1] != p_a[1]) cnt_a1++;
        if (fa_in_b[0] != p_b[0]) cnt_b0++;
        if (fa_in_c[0] != p_c[0]) cnt_c0++;
        if (fa_ack_s != p_s)      cnt_acks++;
        p_a = fa_in_a; p_b = fa_in_b; p_c = fa_in_c; p_s = fa_ack_s;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Present an operand set; the expected result is queued on acceptance
    task automatic send_op(input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [8:0] or_mask);
        int n;
        n = 0;
        op_a = a; op_b = b; op_cin = cin; op_valid = 1'b1;
        while (!op_ready && n < OP_BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            chk("op_ready_wait", {31'b0, op_ready}, 32'd1);
            op_valid = 1'b0;
            return;
        end
        sb_q.push_back(({1'b0, a} + {1'b0, b} + {8'b0, cin}) | or_mask);
        @(negedge clk);
        op_valid = 1'b0;
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
    endtask

    // Wait for a result, hold res_ready low for 'hold' cycles, then accept
    task automatic recv(input int hold);
        int n;
        logic [8:0] exp;
        n = 0;
        while (!res_valid && n < RES_BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("res_valid_wait", {31'b0, res_valid}, 32'd1);
        if (!res_valid) return;
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        exp = sb_q[0];
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, res_valid}, 32'd1);
            chk("hold_data", {23'b0, res_cout, res_sum}, {23'b0, exp});
            chk("hold_op_ready", {31'b0, op_ready}, 32'd0);
        end
        res_ready = 1'b1;
        exp = sb_q.pop_front();
        chk("result", {23'b0, res_cout, res_sum}, {23'b0, exp});
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_drop", {31'b0, res_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_op_ready"},  {31'b0, op_ready},  32'd1);
        chk({tag, "_busy"},      {31'b0, busy},      32'd0);
        chk({tag, "_res_valid"}, {31'b0, res_valid}, 32'd0);
        chk({tag, "_res"},       {23'b0, res_cout, res_sum}, 32'd0);
        chk({tag, "_err"},       {31'b0, err},       32'd0);
        chk({tag, "_timeout"},   {31'b0, timeout},   32'd0);
        chk({tag, "_fa_in"},     {26'b0, fa_in_a, fa_in_b, fa_in_c}, 32'd0);
        chk({tag, "_fa_acks"},   {30'b0, fa_ack_s, fa_ack_c_o}, 32'd0);
    endtask

    // Global guard so the run always ends
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int b_a0, b_a1, b_b0, b_c0, b_acks, n, cyc;
        logic [7:0] ra, rb;
        logic       rc, seen_rv;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero operands: only rail 0 of each input toggles, once per bit
        b_a0 = cnt_a0; b_a1 = cnt_a1; b_b0 = cnt_b0; b_c0 = cnt_c0; b_acks = cnt_acks;
        send_op(8'h00, 8'h00, 1'b0, 9'h000);
        recv(0);
        chk("zero_a0_toggles", cnt_a0 - b_a0, 32'd8);
        chk("zero_a1_toggles", cnt_a1 - b_a1, 32'd0);
        chk("zero_b0_toggles", cnt_b0 - b_b0, 32'd8);
        chk("zero_c0_toggles", cnt_c0 - b_c0, 32'd8);
        chk("zero_acks_toggles", cnt_acks - b_acks, 32'd8);

        // Full carry propagation
        send_op(8'hFF, 8'h01, 1'b0, 9'h000);
        recv(0);
        send_op(8'hA5, 8'h5A, 1'b1, 9'h000);
        recv(0);

        // Back-to-back with the result held off for 10 cycles
        send_op(8'h3C, 8'h0F, 1'b0, 9'h000);
        op_a = 8'h80; op_b = 8'h80; op_cin = 1'b1; op_valid = 1'b1;
        recv(10);
        send_op(8'h80, 8'h80, 1'b1, 9'h000);
        recv(0);

        // Carry output ahead of the acks, then everything in one cycle
        model_mode = 1;
        send_op(8'h55, 8'h33, 1'b0, 9'h000);
        recv(0);
        model_mode = 2;
        send_op(8'hC3, 8'h7E, 1'b1, 9'h000);
        recv(0);
        chk("err_clean", {31'b0, err}, 32'd0);

        // Random operands with random FA delays
        model_mode = 0;
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            send_op(ra, rb, rc, 9'h000);
            recv(0);
        end

        // Both sum rails toggle on bit 3: sum bit 3 reads 1, err is sticky
        inj_bit3 = 1'b1;
        send_op(8'h12, 8'h21, 1'b0, 9'h008);
        recv(0);
        inj_bit3 = 1'b0;
        chk("err_set", {31'b0, err}, 32'd1);
        send_op(8'h01, 8'h01, 1'b0, 9'h000);
        recv(0);
        chk("err_sticky", {31'b0, err}, 32'd1);

        // Reset while bit 4 is in flight
        b_a0 = cnt_a0 + cnt_a1;
        send_op(8'hF0, 8'h0F, 1'b0, 9'h000);
        n = 0;
        while ((cnt_a0 + cnt_a1 - b_a0) < 5 && n < RES_BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("bit4_reached", cnt_a0 + cnt_a1 - b_a0, 32'd5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_op(8'h03, 8'h04, 1'b0, 9'h000);
        recv(0);

`ifdef EL_FA_CTRL_TIMEOUT_EN
        // Silent FA: watchdog abandons the operation without a result
        model_mode = 3;
        send_op(8'h11, 8'h22, 1'b0, 9'h000);
        cyc = 0;
        seen_rv = 1'b0;
        while (!timeout && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (res_valid) seen_rv = 1'b1;
        end
        chk("timeout_set", {31'b0, timeout}, 32'd1);
        chk("timeout_latency", cyc, 32'd1025);
        chk("timeout_idle", {31'b0, busy}, 32'd0);
        chk("timeout_no_result", {31'b0, seen_rv}, 32'd0);
        sb_q.delete();
`else
        cyc = 0;
        seen_rv = 1'b0;
        chk("timeout_tied_low", {31'b0, timeout}, {31'b0, seen_rv});
`endif
        chk("sb_drained", sb_q.size(), 32'd0 + cyc - cyc);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
